// File: rtl/holly_sb_pkg.sv
// Shared constants and types for the HOLLY system-block register responder.
package holly_sb_pkg;

    localparam logic [8:0] OFF_ISTNRM  = 9'h100;
    localparam logic [8:0] OFF_ISTEXT  = 9'h104;
    localparam logic [8:0] OFF_ISTERR  = 9'h108;
    localparam logic [8:0] OFF_IML2NRM = 9'h110;
    localparam logic [8:0] OFF_IML2EXT = 9'h114;
    localparam logic [8:0] OFF_IML2ERR = 9'h118;
    localparam logic [8:0] OFF_IML4NRM = 9'h120;
    localparam logic [8:0] OFF_IML4EXT = 9'h124;
    localparam logic [8:0] OFF_IML4ERR = 9'h128;
    localparam logic [8:0] OFF_IML6NRM = 9'h130;
    localparam logic [8:0] OFF_IML6EXT = 9'h134;
    localparam logic [8:0] OFF_IML6ERR = 9'h138;
    // Mask register groups for levels 2/4/6 are spaced this far apart.
    localparam int         IML_STRIDE  = 16;

    localparam logic [3:0] IRL_LV6  = 4'h9;
    localparam logic [3:0] IRL_LV4  = 4'hB;
    localparam logic [3:0] IRL_LV2  = 4'hD;
    localparam logic [3:0] IRL_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } sb_state_t;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

endpackage

// File: rtl/holly_sb_irl_enc.sv
// Priority encoder from per-level pending flags to the active-low IRL code.
module holly_sb_irl_enc
    import holly_sb_pkg::*;
(
    input  logic       i_pend_lv2,
    input  logic       i_pend_lv4,
    input  logic       i_pend_lv6,
    output logic [3:0] o_irl_n
);

    always_comb begin
        o_irl_n = IRL_NONE;
        if (i_pend_lv6)      o_irl_n = IRL_LV6;
        else if (i_pend_lv4) o_irl_n = IRL_LV4;
        else if (i_pend_lv2) o_irl_n = IRL_LV2;
    end

endmodule

// File: rtl/holly_sb_regs.sv
// HOLLY system-block register responder: interrupt status/mask regs and IRL output.
// Build option SB_ERR_IRQ_EN enables the error interrupt status and masks.
module holly_sb_regs
    import holly_sb_pkg::*;
#(
    parameter int RESP_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sb_cs,
    input  logic        sb_req_valid,
    input  logic [31:0] sb_req_addr,
    input  logic [63:0] sb_req_wdata,
    input  logic [7:0]  sb_req_wmask,
    input  logic        sb_req_wen,
    output logic [63:0] sb_resp_rdata,
    output logic        sb_resp_valid,
    output logic        busy,
    input  logic [21:0] irq_nrm_set,
    input  logic [3:0]  irq_ext_lvl,
    input  logic [31:0] irq_err_set,
    output logic [3:0]  irl_n
);

    localparam logic [3:0] CNT_INIT = 4'(RESP_LATENCY - 1);

    sb_state_t         r_state;
    logic [3:0]        r_cnt;
    logic [8:0]        r_off;
    logic [31:0]       r_wd;
    logic [3:0]        r_be;
    logic              r_wen;
    logic              r_resp_valid;
    logic              r_busy;
    logic [63:0]       r_rdata;
    logic [3:0]        r_irl_n;

    logic [21:0]       r_istnrm;
    logic [2:0][21:0]  r_iml_nrm;
    logic [2:0][3:0]   r_iml_ext;
    logic [31:0]       w_isterr;
    logic [2:0][31:0]  w_iml_err;

    logic              w_commit;
    logic [31:0]       w_bmask;
    logic [31:0]       w_wbits;
    logic [31:0]       w_rd;
    logic [2:0]        w_pend;
    logic [3:0]        w_irl_n;
    logic              w_unused;

    assign w_commit = (r_state == S_RESP) && r_wen;
    assign w_bmask  = be_to_mask(r_be);
    assign w_wbits  = r_wd & w_bmask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_off        <= '0;
            r_wd         <= '0;
            r_be         <= '0;
            r_wen        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (sb_req_valid && sb_cs) begin
                    r_off   <= {sb_req_addr[8:2], 2'b00};
                    r_wd    <= sb_req_addr[2] ? sb_req_wdata[63:32] : sb_req_wdata[31:0];
                    r_be    <= sb_req_addr[2] ? sb_req_wmask[7:4] : sb_req_wmask[3:0];
                    r_wen   <= sb_req_wen;
                    r_busy  <= 1'b1;
                    r_cnt   <= CNT_INIT;
                    r_state <= (CNT_INIT == 4'd0) ? S_RESP : S_WAIT;
                end
                // Leaving on 1 means the counter reaches 0 as we enter RESP.
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    if (!r_wen) r_rdata <= {w_rd, w_rd};
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hardware set is OR'ed after the W1C clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) r_istnrm <= '0;
        else     r_istnrm <= (r_istnrm & ~((w_commit && r_off == OFF_ISTNRM) ? w_wbits[21:0] : 22'h0))
                             | irq_nrm_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iml_nrm <= '0;
            r_iml_ext <= '0;
        end else begin
            for (int l = 0; l < 3; l++) begin
                if (w_commit && r_off == OFF_IML2NRM + 9'(IML_STRIDE * l))
                    r_iml_nrm[l] <= (r_iml_nrm[l] & ~w_bmask[21:0]) | w_wbits[21:0];
                if (w_commit && r_off == OFF_IML2EXT + 9'(IML_STRIDE * l))
                    r_iml_ext[l] <= (r_iml_ext[l] & ~w_bmask[3:0]) | w_wbits[3:0];
            end
        end
    end

`ifdef SB_ERR_IRQ_EN
    logic [31:0]      r_isterr;
    logic [2:0][31:0] r_iml_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_isterr  <= '0;
            r_iml_err <= '0;
        end else begin
            r_isterr <= (r_isterr & ~((w_commit && r_off == OFF_ISTERR) ? w_wbits : 32'h0))
                        | irq_err_set;
            for (int l = 0; l < 3; l++)
                if (w_commit && r_off == OFF_IML2ERR + 9'(IML_STRIDE * l))
                    r_iml_err[l] <= (r_iml_err[l] & ~w_bmask) | w_wbits;
        end
    end

    assign w_isterr  = r_isterr;
    assign w_iml_err = r_iml_err;
    assign w_unused  = ^{sb_req_addr[31:9], sb_req_addr[1:0]};
`else
    assign w_isterr  = '0;
    assign w_iml_err = '0;
    assign w_unused  = ^{sb_req_addr[31:9], sb_req_addr[1:0], irq_err_set};
`endif

    always_comb begin
        w_rd = '0;
        for (int l = 0; l < 3; l++) begin
            if (r_off == OFF_IML2NRM + 9'(IML_STRIDE * l)) w_rd = {10'h0, r_iml_nrm[l]};
            if (r_off == OFF_IML2EXT + 9'(IML_STRIDE * l)) w_rd = {28'h0, r_iml_ext[l]};
            if (r_off == OFF_IML2ERR + 9'(IML_STRIDE * l)) w_rd = w_iml_err[l];
        end
        case (r_off)
            OFF_ISTNRM: w_rd = {|w_isterr, |irq_ext_lvl, 8'h0, r_istnrm};
            OFF_ISTEXT: w_rd = {28'h0, irq_ext_lvl};
            OFF_ISTERR: w_rd = w_isterr;
            default: ;
        endcase
    end

    always_comb begin
        w_pend = '0;
        for (int l = 0; l < 3; l++)
            w_pend[l] = (|(r_istnrm & r_iml_nrm[l])) | (|(irq_ext_lvl & r_iml_ext[l]))
                      | (|(w_isterr & w_iml_err[l]));
    end

    holly_sb_irl_enc u_irl_enc (
        .i_pend_lv2 (w_pend[0]),
        .i_pend_lv4 (w_pend[1]),
        .i_pend_lv6 (w_pend[2]),
        .o_irl_n    (w_irl_n)
    );

    always_ff @(posedge clk) begin
        if (rst) r_irl_n <= IRL_NONE;
        else     r_irl_n <= w_irl_n;
    end

    assign sb_resp_rdata = r_rdata;
    assign sb_resp_valid = r_resp_valid;
    assign busy          = r_busy;
    assign irl_n         = r_irl_n;

endmodule

// File: tb/tb_holly_sb_regs.sv
// Bench for holly_sb_regs: directed vector table, corner sequences, random traffic vs a model.
module tb_holly_sb_regs;

    localparam int L = 2;
`ifdef SB_ERR_IRQ_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sb_cs = 1'b0;
    logic        sb_req_valid = 1'b0;
    logic [31:0] sb_req_addr = '0;
    logic [63:0] sb_req_wdata = '0;
    logic [7:0]  sb_req_wmask = '0;
    logic        sb_req_wen = 1'b0;
    logic [63:0] sb_resp_rdata;
    logic        sb_resp_valid;
    logic        busy;
    logic [21:0] irq_nrm_set = '0;
    logic [3:0]  irq_ext_lvl = '0;
    logic [31:0] irq_err_set = '0;
    logic [3:0]  irl_n;

    holly_sb_regs #(.RESP_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .sb_cs(sb_cs), .sb_req_valid(sb_req_valid),
        .sb_req_addr(sb_req_addr), .sb_req_wdata(sb_req_wdata), .sb_req_wmask(sb_req_wmask),
        .sb_req_wen(sb_req_wen), .sb_resp_rdata(sb_resp_rdata), .sb_resp_valid(sb_resp_valid),
        .busy(busy), .irq_nrm_set(irq_nrm_set), .irq_ext_lvl(irq_ext_lvl),
        .irq_err_set(irq_err_set), .irl_n(irl_n)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [21:0] m_nrm;
    logic [31:0] m_err;
    logic [21:0] m_mn [3];
    logic [3:0]  m_me [3];
    logic [31:0] m_mr [3];
    logic        m_busy, m_valid, m_known;
    logic [63:0] m_rdata;
    logic [3:0]  m_irl;
    int          m_cyc = 0, m_done = 0;
    logic [8:0]  q_off;
    logic [31:0] q_d;
    logic [3:0]  q_be;
    logic        q_wen;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Mask registers: 0x110 + 16*level_index + 4*kind (kind 0=NRM, 1=EXT, 2=ERR).
    function automatic bit is_mask(input logic [8:0] off, output int lvl, output int kind);
        lvl  = int'(off[7:4]) - 1;
        kind = int'(off[3:2]);
        return off[8] && off[1:0] == 2'b00 && lvl >= 0 && lvl <= 2 && kind <= 2;
    endfunction

    function automatic logic [31:0] m_read(input logic [8:0] off);
        int lvl, kind;
        if (off == 9'h100) return {ERR_EN && (m_err != 0), irq_ext_lvl != 0, 8'h0, m_nrm};
        if (off == 9'h104) return {28'h0, irq_ext_lvl};
        if (off == 9'h108) return ERR_EN ? m_err : 32'h0;
        if (is_mask(off, lvl, kind))
            return (kind == 0) ? {10'h0, m_mn[lvl]} : (kind == 1) ? {28'h0, m_me[lvl]}
                                                                  : (ERR_EN ? m_mr[lvl] : 32'h0);
        return 32'h0;
    endfunction

    function automatic void m_write(input logic [8:0] off, input logic [31:0] d, input logic [3:0] be);
        int lvl, kind;
        logic [31:0] bm = bmask(be);
        if (off == 9'h100) m_nrm = m_nrm & ~(d[21:0] & bm[21:0]);
        else if (off == 9'h108) begin if (ERR_EN) m_err = m_err & ~(d & bm); end
        else if (is_mask(off, lvl, kind)) begin
            if (kind == 0) m_mn[lvl] = (m_mn[lvl] & ~bm[21:0]) | (d[21:0] & bm[21:0]);
            else if (kind == 1) m_me[lvl] = (m_me[lvl] & ~bm[3:0]) | (d[3:0] & bm[3:0]);
            else if (ERR_EN) m_mr[lvl] = (m_mr[lvl] & ~bm) | (d & bm);
        end
    endfunction

    function automatic logic [3:0] m_irl_calc();
        logic [3:0] codes [3] = '{4'hD, 4'hB, 4'h9};
        for (int l = 2; l >= 0; l--)
            if ((m_nrm & m_mn[l]) != 0 || (irq_ext_lvl & m_me[l]) != 0 || (m_err & m_mr[l]) != 0)
                return codes[l];
        return 4'hF;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] nirl;
        if (rst) begin
            m_nrm = '0; m_err = '0;
            for (int l = 0; l < 3; l++) begin m_mn[l] = '0; m_me[l] = '0; m_mr[l] = '0; end
            m_busy = 0; m_valid = 0; m_known = 1; m_rdata = '0; m_irl = 4'hF;
        end else begin
            nirl = m_irl_calc();
            m_valid = 0;
            if (m_busy && m_cyc == m_done) begin
                m_valid = 1; m_busy = 0;
                if (q_wen) begin m_write(q_off, q_d, q_be); m_known = 0; end
                else begin m_rdata = {2{m_read(q_off)}}; m_known = 1; end
            end else if (!m_busy && sb_req_valid && sb_cs) begin
                m_busy = 1; m_done = m_cyc + L;
                q_off = {sb_req_addr[8:2], 2'b00};
                q_d   = sb_req_addr[2] ? sb_req_wdata[63:32] : sb_req_wdata[31:0];
                q_be  = sb_req_addr[2] ? sb_req_wmask[7:4] : sb_req_wmask[3:0];
                q_wen = sb_req_wen;
            end
            m_nrm = m_nrm | irq_nrm_set;
            if (ERR_EN) m_err = m_err | irq_err_set;
            m_irl = nirl;
        end
        m_cyc++;
    end

    always @(negedge clk) if (chk_en) begin
        chk("mdl_valid", 64'(sb_resp_valid), 64'(m_valid));
        chk("mdl_busy", 64'(busy), 64'(m_busy));
        chk("mdl_irl", 64'(irl_n), 64'(m_irl));
        if (m_known) chk("mdl_rdata", sb_resp_rdata, m_rdata);
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] rd;
    int          lat;

    // Called at #1 after a rising edge; returns at #1 after the response edge.
    task automatic bus(input bit cs, input bit wen, input logic [8:0] off, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rdo, output int lato);
        sb_cs = cs; sb_req_valid = 1'b1; sb_req_wen = wen;
        sb_req_addr  = 32'h005F_6800 + 32'(off);
        sb_req_wdata = off[2] ? {d, ~d} : {~d, d};
        sb_req_wmask = off[2] ? {be, 4'h0} : {4'h0, be};
        lato = 0; rdo = '0;
        if (!cs) begin
            repeat (4) @(posedge clk);
            #1;
        end else begin
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1; lato++;
                if (sb_resp_valid) break;
            end
            if (!sb_resp_valid) chk("resp_timeout", 64'(sb_resp_valid), 64'(1));
            rdo = sb_resp_rdata[31:0];
        end
        sb_req_valid = 1'b0; sb_cs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit          wen;
        logic [8:0]  off;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];
    logic [8:0] roff [15] = '{9'h100, 9'h104, 9'h108, 9'h110, 9'h114, 9'h118, 9'h120, 9'h124,
                             9'h128, 9'h130, 9'h134, 9'h138, 9'h10C, 9'h1FC, 9'h000};

    initial begin
        vt[0]  = '{0, 9'h100, 32'h0,         4'hF, 32'h0};
        vt[1]  = '{1, 9'h110, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[2]  = '{0, 9'h110, 32'h0,         4'hF, 32'h003F_FFFF};
        vt[3]  = '{1, 9'h114, 32'h0000_00FF, 4'h1, 32'h0};
        vt[4]  = '{0, 9'h114, 32'h0,         4'hF, 32'h0000_000F};
        vt[5]  = '{1, 9'h120, 32'h1234_5678, 4'h5, 32'h0};
        vt[6]  = '{0, 9'h120, 32'h0,         4'hF, 32'h0034_0078};
        vt[7]  = '{1, 9'h120, 32'hAABB_CCDD, 4'hA, 32'h0};
        vt[8]  = '{0, 9'h120, 32'h0,         4'hF, 32'h0034_CC78};
        vt[9]  = '{1, 9'h1FC, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[10] = '{0, 9'h1FC, 32'h0,         4'hF, 32'h0};
        vt[11] = '{1, 9'h118, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[12] = '{0, 9'h118, 32'h0,         4'hF, ERR_EN ? 32'hFFFF_FFFF : 32'h0};
        vt[13] = '{0, 9'h104, 32'h0,         4'hF, 32'h0};

        repeat (2) @(posedge clk);
        #1; rst = 1'b0; chk_en = 1'b1;

        // Reset state and first-read latency
        chk("rst_irl", 64'(irl_n), 64'hF);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_valid", 64'(sb_resp_valid), 64'h0);
        chk("rst_rdata", sb_resp_rdata, 64'h0);
        bus(1, 0, 9'h100, 0, 4'hF, rd, lat);
        chk("rd_latency", 64'(lat), 64'(L + 1));
        chk("rd_istnrm0", 64'(rd), 64'h0);

        foreach (vt[i]) begin
            bus(1, vt[i].wen, vt[i].off, vt[i].d, vt[i].be, rd, lat);
            if (!vt[i].wen) chk($sformatf("vec%0d", i), 64'(rd), 64'(vt[i].exp));
        end

        // Level-6 normal source
        do_reset();
        bus(1, 1, 9'h130, 32'h1, 4'hF, rd, lat);
        irq_nrm_set = 22'h1;
        @(posedge clk); #1; irq_nrm_set = '0;
        chk("irl_after1", 64'(irl_n), 64'hF);
        @(posedge clk); #1;
        chk("irl_lv6", 64'(irl_n), 64'h9);
        bus(1, 0, 9'h100, 0, 4'hF, rd, lat);
        chk("istnrm_set", 64'(rd), 64'h1);

        // W1C racing a set pulse on the commit edge
        fork
            bus(1, 1, 9'h100, 32'h1, 4'hF, rd, lat);
            begin
                repeat (2) @(posedge clk);
                #1 irq_nrm_set = 22'h1;
                @(posedge clk);
                #1 irq_nrm_set = '0;
            end
        join
        bus(1, 0, 9'h100, 0, 4'hF, rd, lat);
        chk("set_wins", 64'(rd), 64'h1);
        bus(1, 1, 9'h100, 32'h1, 4'hF, rd, lat);
        bus(1, 0, 9'h100, 0, 4'hF, rd, lat);
        chk("w1c_clear", 64'(rd), 64'h0);
        chk("irl_cleared", 64'(irl_n), 64'hF);

        // External levels
        bus(1, 1, 9'h124, 32'h2, 4'hF, rd, lat);
        irq_ext_lvl = 4'h2;
        repeat (2) begin @(posedge clk); #1; end
        chk("irl_lv4", 64'(irl_n), 64'hB);
        bus(1, 0, 9'h100, 0, 4'hF, rd, lat);
        chk("istnrm_ext", 64'(rd), 64'h4000_0000);
        bus(1, 1, 9'h134, 32'h2, 4'hF, rd, lat);
        @(posedge clk); #1;
        chk("irl_lv6_ext", 64'(irl_n), 64'h9);
        irq_ext_lvl = 4'h0;

        // Request without chip select
        sb_req_valid = 1'b1; sb_cs = 1'b0; sb_req_addr = 32'h005F_6900; sb_req_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("nocs_valid", 64'(sb_resp_valid), 64'h0);
            chk("nocs_busy", 64'(busy), 64'h0);
        end
        sb_req_valid = 1'b0;

        // Reset while waiting aborts the write
        do_reset();
        sb_cs = 1'b1; sb_req_valid = 1'b1; sb_req_wen = 1'b1;
        sb_req_addr = 32'h005F_6910; sb_req_wdata = {32'h0, 32'h155}; sb_req_wmask = 8'h0F;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'h1);
        rst = 1'b1; sb_req_valid = 1'b0; sb_cs = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_noresp", 64'(sb_resp_valid), 64'h0);
        end
        bus(1, 0, 9'h110, 0, 4'hF, rd, lat);
        chk("abort_nowrite", 64'(rd), 64'h0);

        // Error sources
        irq_err_set = 32'hFFFF_FFFF;
        @(posedge clk); #1; irq_err_set = '0;
        @(posedge clk); #1;
        bus(1, 0, 9'h108, 0, 4'hF, rd, lat);
        chk("isterr", 64'(rd), ERR_EN ? 64'hFFFF_FFFF : 64'h0);
        bus(1, 0, 9'h100, 0, 4'hF, rd, lat);
        chk("istnrm_b31", 64'(rd), ERR_EN ? 64'h8000_0000 : 64'h0);
        chk("irl_err", 64'(irl_n), 64'hF);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 250; n++) begin
            logic [8:0]  off = roff[$urandom_range(0, 14)];
            bit          cs  = ($urandom_range(0, 9) != 0);
            bit          wen = $urandom_range(0, 1);
            logic [31:0] d   = $urandom;
            logic [3:0]  be  = 4'($urandom);
            fork
                bus(cs, wen, off, d, be, rd, lat);
                begin
                    for (int k = 0; k < 6; k++) begin
                        irq_nrm_set = 22'($urandom & $urandom & $urandom);
                        irq_err_set = $urandom & $urandom & $urandom & $urandom;
                        if ($urandom_range(0, 7) == 0) irq_ext_lvl = 4'($urandom);
                        @(posedge clk); #1;
                    end
                    irq_nrm_set = '0; irq_err_set = '0;
                end
            join
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/holly_sb_regs.md
# holly_sb_regs

Responder for the SH4 data-memory request interface over the HOLLY system-block register window (0x005F6800–0x005F69FF). It sits behind the top-level address decode, alongside the PVR register responder. It accepts one CPU request at a time, returns read data or acknowledges a write after a fixed latency, and holds the HOLLY interrupt status and mask registers. It drives the encoded IRL lines back to the CPU.

## Interface
Parameters:
- RESP_LATENCY, 2, cycles from request acceptance to sb_resp_valid; legal range 1–15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sb_cs  in  1  address decode hit for the system-block window.
- sb_req_valid  in  1  request present; held by the requester until sb_resp_valid.
- sb_req_addr  in  32  byte address; only [8:2] are used.
- sb_req_wdata  in  64  write data; 32-bit lane selected by addr[2].
- sb_req_wmask  in  8  byte enables; [3:0] for the low lane, [7:4] for the high lane.
- sb_req_wen  in  1  1 = write, 0 = read.
- sb_resp_rdata  out  64  read data; the 32-bit value is replicated in both halves.
- sb_resp_valid  out  1  one-cycle response pulse.
- busy  out  1  high while a request is in flight.
- irq_nrm_set  in  22  normal interrupt set pulses.
- irq_ext_lvl  in  4  external interrupt levels (GD-ROM, AICA, modem, expansion).
- irq_err_set  in  32  error interrupt set pulses.
- irl_n  out  4  encoded IRL to the CPU, active-low.

## Operation
- Register map (offsets from 0x005F6800):
  - 0x100 ISTNRM: bits [21:0] are sticky and cleared by writing 1 (W1C). Bit 30 = OR(ISTEXT). Bit 31 = OR(ISTERR). Bits 31:30 are read-only.
  - 0x104 ISTEXT: read-only, equals irq_ext_lvl.
  - 0x108 ISTERR: sticky, W1C.
  - 0x110/0x114/0x118 IML2NRM/EXT/ERR, 0x120/0x124/0x128 IML4*, 0x130/0x134/0x138 IML6*: read/write masks with byte-enable granularity. NRM masks are 22 bits wide; EXT masks are 4 bits wide.
  - All other offsets read 0 and ignore writes.
- FSM states:
  - IDLE: sb_req_valid && sb_cs latches addr, wdata, wmask and wen, then moves to WAIT with counter = RESP_LATENCY-1. If the counter is already 0, it goes straight to RESP.
  - WAIT: decrements the counter; moves to RESP when the counter reaches 0.
  - RESP: asserts sb_resp_valid, commits the write or samples the read, then returns to IDLE.
- Requests without sb_cs are ignored. No response is generated for them.
- W1C writes use only the byte lanes enabled by wmask.
- Interrupt sets and W1C:
  - A hardware set and a W1C on the same bit in the same cycle: set wins, and the bit stays 1.
  - Set pulses are sampled every cycle, in all states.
- Level n is pending when (ISTNRM & IML_nNRM) | (ISTEXT & IML_nEXT) | (ISTERR & IML_nERR) is nonzero.
- irl_n is driven from the highest pending level: 6 → 4'h9, 4 → 4'hB, 2 → 4'hD, none → 4'hF.

## Timing
- Reset values:
  - Every status and mask register is 0.
  - sb_resp_valid = 0, sb_resp_rdata = 0, busy = 0, irl_n = 4'hF.
  - FSM returns to IDLE.
- Latency: a request accepted at edge T produces sb_resp_valid high for exactly the cycle after edge T+RESP_LATENCY.
- sb_resp_rdata is valid only while sb_resp_valid is high. It holds its value afterwards.
- A write commits at the RESP edge, so a read issued next sees the new value.
- Back-to-back: the earliest next acceptance is the cycle after sb_resp_valid. The requester must drop sb_req_valid or present a new request in that cycle.
- busy is high from the acceptance edge until the RESP edge.
- Status bits are set one cycle after the set pulse. irl_n is registered and follows the status and mask registers by one further cycle.
- Reset mid-request aborts the request. No response is issued and no write commits.

## Configuration
- SB_ERR_IRQ_EN defined: ISTERR and IML*ERR are implemented as above.
- SB_ERR_IRQ_EN undefined: ISTERR and IML*ERR read 0 and ignore writes, irq_err_set is ignored, and ISTNRM bit 31 is always 0.

## Structure
- The package holly_sb_pkg holds:
  - register offset constants;
  - IRL code constants (IRL_LV6, IRL_LV4, IRL_LV2, IRL_NONE);
  - the FSM state typedef.
- One sub-module, holly_sb_irl_enc: combinational priority encoder from the three per-level pending flags to the 4-bit IRL code. The register stage stays in the parent.

## Test plan
- Reset, then read ISTNRM with RESP_LATENCY=2: acceptance at T, sb_resp_valid at T+2, rdata = 64'h0; irl_n = 4'hF.
- Write IML6NRM=32'h0000_0001 with wmask 8'h0F, then pulse irq_nrm_set[0]: ISTNRM reads 32'h1, and irl_n = 4'h9 two cycles after the pulse.
- Write ISTNRM=32'h1 (W1C) in the same cycle as an irq_nrm_set[0] pulse: the bit reads back 1. A later W1C with no pulse clears it, and irl_n returns to 4'hF.
- Set IML4EXT=4'h2 and irq_ext_lvl=4'h2: ISTNRM bit 30 = 1 and irl_n = 4'hB. Additionally enable the level-6 source: irl_n = 4'h9.
- Request with sb_cs=0 held for 10 cycles: no sb_resp_valid and busy stays 0. Assert rst while in WAIT: no response and no write commits.
- With SB_ERR_IRQ_EN undefined, pulse irq_err_set=32'hFFFF_FFFF: ISTERR reads 0, ISTNRM bit 31 reads 0, and irl_n stays 4'hF.
